// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN process graph: token/operand widths and the
// default channel depth, so producers, channels and consumers agree on sizes.
package kpn_pkg;

    localparam int KPN_OPERAND_W  = 16;
    localparam int KPN_TOKEN_W    = 32;
    localparam int KPN_CHAN_DEPTH = 8;

    typedef logic [KPN_TOKEN_W-1:0]   kpn_token_t;
    typedef logic [KPN_OPERAND_W-1:0] kpn_operand_t;

endpackage

// File: rtl/kpn_channel_fifo_if.sv
// Producer/consumer signal bundle of one KPN channel; the FIFO takes the slave
// side, whoever drives the strobes takes the master side.
interface kpn_channel_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);

    // Strobe semantics: wr/rd are level strobes sampled at each rising edge.
    // A write counts only when !full (or a read is accepted in the same
    // cycle); a read counts only when !empty. Rejected strobes set the sticky
    // overflow/underflow flags. An accepted read returns its token on data_out
    // one cycle later, marked by a single-cycle data_valid pulse.
    logic                  wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  wr, data_in, rd,
        output full, data_out, data_valid, empty, count, overflow, underflow
    );

    modport master (
        output wr, data_in, rd,
        input  full, data_out, data_valid, empty, count, overflow, underflow
    );

endinterface

// File: rtl/kpn_fifo_mem.sv
// Token storage for the channel: one synchronous write port and one
// synchronous read port whose output register holds until the next read.
module kpn_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write on a shared address, so a full-channel read+write
    // returns the oldest token while the new one replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/kpn_channel_fifo.sv
// Blocking FIFO channel between KPN processes: pointer, occupancy, flag and
// handshake logic around a kpn_fifo_mem storage array.
module kpn_channel_fifo
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_TOKEN_W,
    parameter int DEPTH      = KPN_CHAN_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    kpn_channel_fifo_if.slave   ch
);

    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // A read frees a slot in the same cycle, so a full channel still takes a
    // write when it is also being read.
    always_comb begin
        rd_acc  = ch.rd & ~empty_q;
        wr_acc  = ch.wr & (~full_q | rd_acc);
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Flags come from the next occupancy so they are registered and free of
    // the pointer-equality full/empty ambiguity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q     <= count_d;
            full_q      <= (count_d == COUNT_FULL);
            empty_q     <= (count_d == '0);
            valid_q     <= rd_acc;
            overflow_q  <= overflow_q  | (ch.wr & ~wr_acc);
            underflow_q <= underflow_q | (ch.rd & ~rd_acc);
        end
    end

    kpn_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (ch.data_in),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ch.data_out)
    );

    assign ch.full       = full_q;
    assign ch.empty      = empty_q;
    assign ch.count      = count_q;
    assign ch.data_valid = valid_q;
    assign ch.overflow   = overflow_q;
    assign ch.underflow  = underflow_q;

endmodule

// File: tb/tb_kpn_channel_fifo.sv
// Directed plus randomized bench for kpn_channel_fifo, checked cycle by cycle
// against a queue-based model of the channel.
module tb_kpn_channel_fifo;
    import kpn_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk;
    logic reset_n;

    kpn_channel_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ch();

    kpn_channel_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ch      (ch)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    kpn_token_t    m_dout;
    logic          m_dv;
    logic          m_ovf;
    logic          m_unf;
    int            n_vec;
    int            n_err;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},      DW'(ch.count),      DW'(exp_q.size()));
        check({tag, ".empty"},      DW'(ch.empty),      DW'(exp_q.size() == 0));
        check({tag, ".full"},       DW'(ch.full),       DW'(exp_q.size() == DEPTH));
        check({tag, ".data_valid"}, DW'(ch.data_valid), DW'(m_dv));
        check({tag, ".data_out"},   ch.data_out,        m_dout);
        check({tag, ".overflow"},   DW'(ch.overflow),   DW'(m_ovf));
        check({tag, ".underflow"},  DW'(ch.underflow),  DW'(m_unf));
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    // driver: apply one cycle of strobes (called at posedge+1), update the
    // model at the edge, then compare 1 time unit after it
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
        int   n;
        logic rd_ok;
        logic wr_ok;
        ch.wr      = w;
        ch.data_in = d;
        ch.rd      = r;
        @(posedge clk);
        n     = exp_q.size();
        rd_ok = r && (n > 0);
        wr_ok = w && ((n < DEPTH) || rd_ok);
        if (w && !wr_ok) m_ovf = 1'b1;
        if (r && !rd_ok) m_unf = 1'b1;
        m_dv = rd_ok;
        if (rd_ok) m_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        #1;
        check_all(tag);
        ch.wr = 1'b0;
        ch.rd = 1'b0;
    endtask

    // asynchronous reset pulse, placed between clock edges
    task automatic async_reset(input string tag);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ".post"});
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        ch.wr      = 1'b0;
        ch.rd      = 1'b0;
        ch.data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // three products through the channel
        step("t1.w0", 1'b1, 32'd15,    1'b0);
        step("t1.w1", 1'b1, 32'd200,   1'b0);
        step("t1.w2", 1'b1, 32'd65535, 1'b0);
        check("t1.count3", DW'(ch.count), 32'd3);
        step("t1.r0", 1'b0, $urandom, 1'b1);
        check("t1.first", ch.data_out, 32'd15);
        step("t1.r1", 1'b0, $urandom, 1'b1);
        step("t1.r2", 1'b0, $urandom, 1'b1);
        check("t1.last", ch.data_out, 32'd65535);
        step("t1.idle", 1'b0, $urandom, 1'b0);
        check("t1.empty", DW'(ch.empty), 32'd1);

        // fill, overflow attempt, drain
        for (int i = 1; i <= DEPTH; i++) step("t2.fill", 1'b1, DW'(i), 1'b0);
        check("t2.full", DW'(ch.full), 32'd1);
        step("t2.ovf", 1'b1, 32'd99, 1'b0);
        check("t2.overflow", DW'(ch.overflow), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            step("t2.drain", 1'b0, $urandom, 1'b1);
            check("t2.order", ch.data_out, DW'(i));
        end

        // full with simultaneous read and write
        for (int i = 1; i <= DEPTH; i++) step("t3.fill", 1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("t3.rw", 1'b1, DW'(100 + i), 1'b1);
            check("t3.rw_out", ch.data_out, DW'(i + 1));
        end
        for (int i = 0; i < DEPTH; i++) step("t3.drain", 1'b0, $urandom, 1'b1);
        check("t3.tail", ch.data_out, 32'd103);

        // empty-channel read, then write+read from empty
        step("t4.rd_empty", 1'b0, $urandom, 1'b1);
        check("t4.underflow", DW'(ch.underflow), 32'd1);
        step("t4.wr_rd", 1'b1, 32'd42, 1'b1);
        step("t4.rd", 1'b0, $urandom, 1'b1);
        check("t4.val42", ch.data_out, 32'd42);

        // pointer wrap with alternating write/read
        for (int i = 0; i < 20; i++) begin
            step("t5.w", 1'b1, DW'(32'h1000 + i), 1'b0);
            step("t5.r", 1'b0, $urandom, 1'b1);
        end

        // asynchronous reset with 5 tokens stored
        for (int i = 0; i < 5; i++) step("t6.fill", 1'b1, $urandom, 1'b0);
        async_reset("t6.reset");
        step("t6.rd", 1'b0, $urandom, 1'b1);

        // randomized traffic, with one more mid-stream reset
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 50));
            if (i == 200) async_reset("rand.reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
